alu_issue_stage: RTL and testbench
==================================

// Module: alu_issue_stage
// PURPOSE
//  Producer side of the ALU opcode/operand interface. Decodes a MIPS instruction (op/funct) into the 4-bit ALU opcode.
//  Selects/extends both ALU operands and holds them in a single-entry ID/EX register with valid/ready handshake.
//  Sits between register-file read (upstream) and the ALU (downstream); supports stall (backpressure) and flush.
// PARAMETERS
//  registers_data_width      32  operand/result width
//  alu_control_opcode_width  4   ALU opcode width (encoding below requires >=4)
//  count_width               16  width of issued-instruction counter
// PORTS
//  clk             in   1      rising-edge clock; sole clock domain
//  rst_n           in   1      asynchronous, active-low reset
//  in_valid        in   1      upstream presents instruction + register data
//  in_ready        out  1      stage can accept this cycle
//  in_instruction  in   32     raw MIPS instruction word
//  in_rs_data      in   W      GPR[rs] value
//  in_rt_data      in   W      GPR[rt] value
//  flush           in   1      squash held entry (branch/exception)
//  out_valid       out  1      held entry valid toward ALU
//  out_ready       in   1      ALU/EX consumes entry this cycle
//  out_alu_opcode  out  4      ALU operation code
//  out_operand1    out  W      ALU data1 (shift amount for shifts)
//  out_operand2    out  W      ALU data2 (shifted value for shifts)
//  out_dest_reg    out  5      destination GPR index
//  out_reg_write   out  1      destination written back
//  out_illegal     out  1      unsupported op/funct
//  out_issue_count out  count_width  entries accepted since reset, saturating
// BEHAVIOUR
//  Opcodes: SLL 0, SRL 1, SRA 2, ADD 3, SUB 4, AND 5, OR 6, XOR 7, NOR 8, SLT 9, LUI 10, ILLEGAL 15.
//  R-type (op 0x00), funct: 00 SLL, 02 SRL, 03 SRA -> op1 = zero-ext shamt, op2 = rt.
//   04/06/07 SLLV/SRLV/SRAV -> op1 = rs[4:0] zero-ext, op2 = rt.
//   21 ADDU, 23 SUBU, 24 AND, 25 OR, 26 XOR, 27 NOR, 2A SLT -> op1 = rs, op2 = rt.
//   R-type: dest = rd, reg_write = 1.
//  I-type: 08/09 ADDI/ADDIU ADD sign-ext; 0A SLTI SLT sign-ext.
//   0C/0D/0E ANDI/ORI/XORI zero-ext.
//   0F LUI: opcode 10, op2 = zero-ext imm, op1 = 0.
//   I-type: dest = rt, reg_write = 1.
//  Loads 20,21,23,24,25: ADD, op1 = rs, op2 = sign-ext imm, dest = rt, reg_write = 1.
//  Stores 28,29,2B: ADD, sign-ext imm, reg_write = 0.
//  BEQ 04 / BNE 05: SUB, op1 = rs, op2 = rt, reg_write = 0.
//  Anything else: opcode 15, op1 = op2 = 0, reg_write = 0, illegal = 1; still handshaken normally.
//  Rule: reg_write forced 0 when dest == 0.
//  Handshake: in_ready = !out_valid | out_ready (combinational; no input->output data path).
//   Load when in_valid & in_ready & !flush: all out_* registered next edge, out_valid = 1.
//   out_ready & !load: out_valid -> 0.
//   !out_ready: all outputs hold stable.
//  Latency: 1 cycle; throughput 1/cycle when out_ready held high.
//  flush: highest priority; next edge out_valid = 0, input that cycle dropped (no count increment), in_ready unaffected.
//  out_issue_count: +1 per accepted (non-flushed) load; saturates at all-ones.
//  Reset (async assert, sync deassert by caller): out_valid = 0, out_alu_opcode = 0, operands = 0, dest = 0.
//   Reset values (cont.): reg_write = 0, illegal = 0, count = 0.
//   Reset mid-transfer discards the entry.
//  Data fields update only on load (hold while out_valid = 0), so idle outputs show the last issued entry.
// STRUCTURE
//  Package alu_issue_pkg: ALU opcode localparams (0-10, 15), MIPS op/funct constants, ext helper functions.
//  Sub-module alu_issue_decode: pure combinational decode (instruction, rs, rt -> opcode, op1, op2, dest, reg_write, illegal).
//  Top holds the handshake, pipeline register and counter.
// TESTING
//  ADDU $3,$1,$2 with rs=5, rt=7 -> next cycle opcode 3, op1 5, op2 7, dest 3, reg_write 1, valid 1.
//  SRA $4,$2,8 (shamt 8, rt=0x80000000) -> opcode 2, op1 8, op2 0x80000000, dest 4.
//  LUI $5,0x1234 -> opcode 10, op2 0x00001234; ORI rt=6, imm 0x8000 -> op2 0x00008000 (zero-ext).
//  ADDI imm 0xFFFF -> op2 0xFFFFFFFF; SW -> reg_write 0; ADDU rd=0 -> reg_write 0; op 0x3F -> illegal 1, opcode 15.
//  Backpressure: out_ready = 0 for 3 cycles with in_valid = 1 -> in_ready 0, outputs stable, count +1 only; release -> next entry loads.
//  flush with in_valid = 1, in_ready = 1 -> out_valid 0 next cycle, count unchanged; rst_n pulse mid-stream -> all outputs zero immediately.

Source files
------------

// File: rtl/alu_issue_pkg.sv
// Shared ALU opcode encodings, MIPS op/funct field values and immediate
// extension helpers for the ALU issue stage.
package alu_issue_pkg;

    typedef logic [3:0] alu_op_t;

    localparam alu_op_t ALU_SLL     = 4'd0;
    localparam alu_op_t ALU_SRL     = 4'd1;
    localparam alu_op_t ALU_SRA     = 4'd2;
    localparam alu_op_t ALU_ADD     = 4'd3;
    localparam alu_op_t ALU_SUB     = 4'd4;
    localparam alu_op_t ALU_AND     = 4'd5;
    localparam alu_op_t ALU_OR      = 4'd6;
    localparam alu_op_t ALU_XOR     = 4'd7;
    localparam alu_op_t ALU_NOR     = 4'd8;
    localparam alu_op_t ALU_SLT     = 4'd9;
    localparam alu_op_t ALU_LUI     = 4'd10;
    localparam alu_op_t ALU_ILLEGAL = 4'd15;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LB    = 6'h20;
    localparam logic [5:0] OP_LH    = 6'h21;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_LBU   = 6'h24;
    localparam logic [5:0] OP_LHU   = 6'h25;
    localparam logic [5:0] OP_SB    = 6'h28;
    localparam logic [5:0] OP_SH    = 6'h29;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] F_SLL  = 6'h00;
    localparam logic [5:0] F_SRL  = 6'h02;
    localparam logic [5:0] F_SRA  = 6'h03;
    localparam logic [5:0] F_SLLV = 6'h04;
    localparam logic [5:0] F_SRLV = 6'h06;
    localparam logic [5:0] F_SRAV = 6'h07;
    localparam logic [5:0] F_ADDU = 6'h21;
    localparam logic [5:0] F_SUBU = 6'h23;
    localparam logic [5:0] F_AND  = 6'h24;
    localparam logic [5:0] F_OR   = 6'h25;
    localparam logic [5:0] F_XOR  = 6'h26;
    localparam logic [5:0] F_NOR  = 6'h27;
    localparam logic [5:0] F_SLT  = 6'h2A;

    // Operand source and destination selectors produced by decode.
    typedef enum logic [2:0] {
        SRC_ZERO,
        SRC_RS,
        SRC_RT,
        SRC_SHAMT,
        SRC_RS_LOW5,
        SRC_SIMM,
        SRC_ZIMM
    } src_t;

    typedef enum logic [1:0] {
        DST_NONE,
        DST_RD,
        DST_RT
    } dst_t;

    // Helpers extend to a wide fixed size; callers size-cast to the datapath width.
    localparam int EXT_W = 64;

    function automatic logic [EXT_W-1:0] sign_ext16(input logic [15:0] imm);
        return {{(EXT_W-16){imm[15]}}, imm};
    endfunction

    function automatic logic [EXT_W-1:0] zero_ext16(input logic [15:0] imm);
        return {{(EXT_W-16){1'b0}}, imm};
    endfunction

    function automatic logic [EXT_W-1:0] zero_ext5(input logic [4:0] val);
        return {{(EXT_W-5){1'b0}}, val};
    endfunction

endpackage

// File: rtl/alu_issue_decode.sv
// Combinational MIPS decode: instruction word plus register values in,
// ALU opcode, both operands, destination and write-enable out.
module alu_issue_decode
    import alu_issue_pkg::*;
#(
    parameter int registers_data_width     = 32,
    parameter int alu_control_opcode_width = 4
) (
    input  logic [31:0]                         instruction,
    input  logic [registers_data_width-1:0]     rs_data,
    input  logic [registers_data_width-1:0]     rt_data,
    output logic [alu_control_opcode_width-1:0] alu_opcode,
    output logic [registers_data_width-1:0]     operand1,
    output logic [registers_data_width-1:0]     operand2,
    output logic [4:0]                          dest_reg,
    output logic                                reg_write,
    output logic                                illegal
);

    localparam int W  = registers_data_width;
    localparam int OW = alu_control_opcode_width;

    logic [5:0]  op_field;
    logic [4:0]  rt_field;
    logic [4:0]  rd_field;
    logic [4:0]  shamt_field;
    logic [5:0]  funct_field;
    logic [15:0] imm_field;

    assign op_field    = instruction[31:26];
    assign rt_field    = instruction[20:16];
    assign rd_field    = instruction[15:11];
    assign shamt_field = instruction[10:6];
    assign funct_field = instruction[5:0];
    assign imm_field   = instruction[15:0];

    alu_op_t alu_op;
    src_t    src1;
    src_t    src2;
    dst_t    dst_sel;
    logic    writes;
    logic    bad;

    always_comb begin
        alu_op  = ALU_ILLEGAL;
        src1    = SRC_ZERO;
        src2    = SRC_ZERO;
        dst_sel = DST_NONE;
        writes  = 1'b0;
        bad     = 1'b1;
        case (op_field)
            OP_RTYPE: begin
                bad     = 1'b0;
                writes  = 1'b1;
                dst_sel = DST_RD;
                src1    = SRC_RS;
                src2    = SRC_RT;
                case (funct_field)
                    F_SLL:  begin alu_op = ALU_SLL; src1 = SRC_SHAMT;   end
                    F_SRL:  begin alu_op = ALU_SRL; src1 = SRC_SHAMT;   end
                    F_SRA:  begin alu_op = ALU_SRA; src1 = SRC_SHAMT;   end
                    F_SLLV: begin alu_op = ALU_SLL; src1 = SRC_RS_LOW5; end
                    F_SRLV: begin alu_op = ALU_SRL; src1 = SRC_RS_LOW5; end
                    F_SRAV: begin alu_op = ALU_SRA; src1 = SRC_RS_LOW5; end
                    F_ADDU: alu_op = ALU_ADD;
                    F_SUBU: alu_op = ALU_SUB;
                    F_AND:  alu_op = ALU_AND;
                    F_OR:   alu_op = ALU_OR;
                    F_XOR:  alu_op = ALU_XOR;
                    F_NOR:  alu_op = ALU_NOR;
                    F_SLT:  alu_op = ALU_SLT;
                    default: begin
                        alu_op  = ALU_ILLEGAL;
                        src1    = SRC_ZERO;
                        src2    = SRC_ZERO;
                        dst_sel = DST_NONE;
                        writes  = 1'b0;
                        bad     = 1'b1;
                    end
                endcase
            end
            OP_ADDI, OP_ADDIU: begin
                alu_op = ALU_ADD; src1 = SRC_RS; src2 = SRC_SIMM;
                dst_sel = DST_RT; writes = 1'b1; bad = 1'b0;
            end
            OP_SLTI: begin
                alu_op = ALU_SLT; src1 = SRC_RS; src2 = SRC_SIMM;
                dst_sel = DST_RT; writes = 1'b1; bad = 1'b0;
            end
            OP_ANDI: begin
                alu_op = ALU_AND; src1 = SRC_RS; src2 = SRC_ZIMM;
                dst_sel = DST_RT; writes = 1'b1; bad = 1'b0;
            end
            OP_ORI: begin
                alu_op = ALU_OR; src1 = SRC_RS; src2 = SRC_ZIMM;
                dst_sel = DST_RT; writes = 1'b1; bad = 1'b0;
            end
            OP_XORI: begin
                alu_op = ALU_XOR; src1 = SRC_RS; src2 = SRC_ZIMM;
                dst_sel = DST_RT; writes = 1'b1; bad = 1'b0;
            end
            OP_LUI: begin
                alu_op = ALU_LUI; src1 = SRC_ZERO; src2 = SRC_ZIMM;
                dst_sel = DST_RT; writes = 1'b1; bad = 1'b0;
            end
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
                alu_op = ALU_ADD; src1 = SRC_RS; src2 = SRC_SIMM;
                dst_sel = DST_RT; writes = 1'b1; bad = 1'b0;
            end
            // Stores compute the address only; nothing is written back.
            OP_SB, OP_SH, OP_SW: begin
                alu_op = ALU_ADD; src1 = SRC_RS; src2 = SRC_SIMM;
                bad = 1'b0;
            end
            OP_BEQ, OP_BNE: begin
                alu_op = ALU_SUB; src1 = SRC_RS; src2 = SRC_RT;
                bad = 1'b0;
            end
            default: ;
        endcase
    end

    always_comb begin
        operand1 = '0;
        case (src1)
            SRC_RS:      operand1 = rs_data;
            SRC_RT:      operand1 = rt_data;
            SRC_SHAMT:   operand1 = W'(zero_ext5(shamt_field));
            SRC_RS_LOW5: operand1 = W'(zero_ext5(rs_data[4:0]));
            SRC_SIMM:    operand1 = W'(sign_ext16(imm_field));
            SRC_ZIMM:    operand1 = W'(zero_ext16(imm_field));
            default:     operand1 = '0;
        endcase
    end

    always_comb begin
        operand2 = '0;
        case (src2)
            SRC_RS:      operand2 = rs_data;
            SRC_RT:      operand2 = rt_data;
            SRC_SHAMT:   operand2 = W'(zero_ext5(shamt_field));
            SRC_RS_LOW5: operand2 = W'(zero_ext5(rs_data[4:0]));
            SRC_SIMM:    operand2 = W'(sign_ext16(imm_field));
            SRC_ZIMM:    operand2 = W'(zero_ext16(imm_field));
            default:     operand2 = '0;
        endcase
    end

    always_comb begin
        dest_reg = 5'd0;
        case (dst_sel)
            DST_RD:  dest_reg = rd_field;
            DST_RT:  dest_reg = rt_field;
            default: dest_reg = 5'd0;
        endcase
    end

    // $zero is never a real write target.
    assign reg_write  = writes && (dest_reg != 5'd0);
    assign illegal    = bad;
    assign alu_opcode = OW'(alu_op);

endmodule

// File: rtl/alu_issue_stage.sv
// ID/EX issue stage: decodes an instruction and holds the ALU request in a
// single-entry valid/ready register with flush and a saturating issue counter.
module alu_issue_stage
    import alu_issue_pkg::*;
#(
    parameter int registers_data_width     = 32,
    parameter int alu_control_opcode_width = 4,
    parameter int count_width              = 16
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [31:0]                         in_instruction,
    input  logic [registers_data_width-1:0]     in_rs_data,
    input  logic [registers_data_width-1:0]     in_rt_data,
    input  logic                                flush,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [alu_control_opcode_width-1:0] out_alu_opcode,
    output logic [registers_data_width-1:0]     out_operand1,
    output logic [registers_data_width-1:0]     out_operand2,
    output logic [4:0]                          out_dest_reg,
    output logic                                out_reg_write,
    output logic                                out_illegal,
    output logic [count_width-1:0]              out_issue_count
);

    localparam int W  = registers_data_width;
    localparam int OW = alu_control_opcode_width;

    logic [OW-1:0] dec_opcode;
    logic [W-1:0]  dec_operand1;
    logic [W-1:0]  dec_operand2;
    logic [4:0]    dec_dest_reg;
    logic          dec_reg_write;
    logic          dec_illegal;

    alu_issue_decode #(
        .registers_data_width     (W),
        .alu_control_opcode_width (OW)
    ) u_decode (
        .instruction (in_instruction),
        .rs_data     (in_rs_data),
        .rt_data     (in_rt_data),
        .alu_opcode  (dec_opcode),
        .operand1    (dec_operand1),
        .operand2    (dec_operand2),
        .dest_reg    (dec_dest_reg),
        .reg_write   (dec_reg_write),
        .illegal     (dec_illegal)
    );

    logic                   valid_reg;
    logic [OW-1:0]          opcode_reg;
    logic [W-1:0]           operand1_reg;
    logic [W-1:0]           operand2_reg;
    logic [4:0]             dest_reg_reg;
    logic                   reg_write_reg;
    logic                   illegal_reg;
    logic [count_width-1:0] count_reg;
    logic [count_width-1:0] count_next;
    logic                   load;

    // Ready depends only on the held state and the downstream ready.
    assign in_ready   = !valid_reg || out_ready;
    assign load       = in_valid && in_ready && !flush;
    assign count_next = (count_reg == '1) ? count_reg : count_reg + count_width'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_reg <= 1'b0;
        end else if (flush) begin
            valid_reg <= 1'b0;
        end else if (load) begin
            valid_reg <= 1'b1;
        end else if (out_ready) begin
            valid_reg <= 1'b0;
        end
    end

    // Payload changes only on load so an idle stage still shows the last entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opcode_reg    <= '0;
            operand1_reg  <= '0;
            operand2_reg  <= '0;
            dest_reg_reg  <= '0;
            reg_write_reg <= 1'b0;
            illegal_reg   <= 1'b0;
        end else if (load) begin
            opcode_reg    <= dec_opcode;
            operand1_reg  <= dec_operand1;
            operand2_reg  <= dec_operand2;
            dest_reg_reg  <= dec_dest_reg;
            reg_write_reg <= dec_reg_write;
            illegal_reg   <= dec_illegal;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= count_next;
        end
    end

    assign out_valid       = valid_reg;
    assign out_alu_opcode  = opcode_reg;
    assign out_operand1    = operand1_reg;
    assign out_operand2    = operand2_reg;
    assign out_dest_reg    = dest_reg_reg;
    assign out_reg_write   = reg_write_reg;
    assign out_illegal     = illegal_reg;
    assign out_issue_count = count_reg;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: expected entries are queued when driven
// and compared when the stage hands them to the ALU.
module tb_alu_issue_stage;

    localparam int CW = 4;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [31:0]   in_instruction;
    logic [31:0]   in_rs_data;
    logic [31:0]   in_rt_data;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [3:0]    out_alu_opcode;
    logic [31:0]   out_operand1;
    logic [31:0]   out_operand2;
    logic [4:0]    out_dest_reg;
    logic          out_reg_write;
    logic          out_illegal;
    logic [CW-1:0] out_issue_count;

    alu_issue_stage #(
        .registers_data_width     (32),
        .alu_control_opcode_width (4),
        .count_width              (CW)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .in_valid        (in_valid),
        .in_ready        (in_ready),
        .in_instruction  (in_instruction),
        .in_rs_data      (in_rs_data),
        .in_rt_data      (in_rt_data),
        .flush           (flush),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_alu_opcode  (out_alu_opcode),
        .out_operand1    (out_operand1),
        .out_operand2    (out_operand2),
        .out_dest_reg    (out_dest_reg),
        .out_reg_write   (out_reg_write),
        .out_illegal     (out_illegal),
        .out_issue_count (out_issue_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [3:0]  opc;
        logic [31:0] op1;
        logic [31:0] op2;
        logic [4:0]  dest;
        logic        rw;
        logic        ill;
        bit          chk_dest;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   exp_count = 0;

    function automatic logic [31:0] r_ins(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [4:0] sh,
                                          input logic [5:0] fn);
        return {6'h00, rs, rt, rd, sh, fn};
    endfunction

    function automatic logic [31:0] i_ins(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
        return {op, rs, rt, imm};
    endfunction

    function automatic exp_t mk(input logic [3:0] opc, input logic [31:0] op1,
                                input logic [31:0] op2, input logic [4:0] dest,
                                input logic rw, input logic ill, input bit chk_dest);
        exp_t e;
        e.opc = opc; e.op1 = op1; e.op2 = op2; e.dest = dest;
        e.rw = rw; e.ill = ill; e.chk_dest = chk_dest;
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%h expected=0x%h", tag, obs, exp);
        end
    endtask

    // One clock: compare any entry the ALU takes at this edge, then advance.
    task automatic cycle();
        exp_t e;
        if (out_valid === 1'b1 && out_ready === 1'b1) begin
            if (sb.size() == 0) begin
                chk("sb_underflow", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                $display("xfer opc=%0d op1=%h op2=%h dest=%0d rw=%0b ill=%0b",
                         out_alu_opcode, out_operand1, out_operand2,
                         out_dest_reg, out_reg_write, out_illegal);
                chk("opcode", 32'(out_alu_opcode), 32'(e.opc));
                chk("operand1", out_operand1, e.op1);
                chk("operand2", out_operand2, e.op2);
                if (e.chk_dest) chk("dest_reg", 32'(out_dest_reg), 32'(e.dest));
                chk("reg_write", 32'(out_reg_write), 32'(e.rw));
                chk("illegal", 32'(out_illegal), 32'(e.ill));
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [31:0] ins, input logic [31:0] rs,
                         input logic [31:0] rt, input exp_t e);
        in_valid       = 1'b1;
        in_instruction = ins;
        in_rs_data     = rs;
        in_rt_data     = rt;
        sb.push_back(e);
        if (exp_count != (1 << CW) - 1) exp_count++;
        cycle();
    endtask

    task automatic idle();
        in_valid = 1'b0;
        cycle();
    endtask

    exp_t held;

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_instruction = '0;
        in_rs_data = '0; in_rt_data = '0; flush = 1'b0; out_ready = 1'b1;
        #3;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_opcode", 32'(out_alu_opcode), 32'd0);
        chk("rst_op1", out_operand1, 32'd0);
        chk("rst_op2", out_operand2, 32'd0);
        chk("rst_dest", 32'(out_dest_reg), 32'd0);
        chk("rst_rw", 32'(out_reg_write), 32'd0);
        chk("rst_ill", 32'(out_illegal), 32'd0);
        chk("rst_count", 32'(out_issue_count), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Back-to-back stream with the ALU always ready.
        issue(r_ins(5'd1, 5'd2, 5'd3, 5'd0, 6'h21), 32'd5, 32'd7, mk(4'd3, 32'd5, 32'd7, 5'd3, 1'b1, 1'b0, 1));
        chk("latency_valid", 32'(out_valid), 32'd1);
        issue(r_ins(5'd0, 5'd2, 5'd4, 5'd8, 6'h03), 32'd0, 32'h8000_0000, mk(4'd2, 32'd8, 32'h8000_0000, 5'd4, 1'b1, 1'b0, 1));
        issue(i_ins(6'h0F, 5'd0, 5'd5, 16'h1234), 32'hDEAD, 32'h0, mk(4'd10, 32'd0, 32'h0000_1234, 5'd5, 1'b1, 1'b0, 1));
        issue(i_ins(6'h0D, 5'd1, 5'd6, 16'h8000), 32'h11, 32'h0, mk(4'd6, 32'h11, 32'h0000_8000, 5'd6, 1'b1, 1'b0, 1));
        issue(i_ins(6'h08, 5'd1, 5'd7, 16'hFFFF), 32'd1, 32'h0, mk(4'd3, 32'd1, 32'hFFFF_FFFF, 5'd7, 1'b1, 1'b0, 1));
        issue(i_ins(6'h2B, 5'd1, 5'd2, 16'hFFFC), 32'h100, 32'h55, mk(4'd3, 32'h100, 32'hFFFF_FFFC, 5'd0, 1'b0, 1'b0, 0));
        issue(r_ins(5'd1, 5'd2, 5'd0, 5'd0, 6'h21), 32'd9, 32'd10, mk(4'd3, 32'd9, 32'd10, 5'd0, 1'b0, 1'b0, 1));
        issue(i_ins(6'h3F, 5'd1, 5'd2, 16'h1111), 32'd3, 32'd4, mk(4'd15, 32'd0, 32'd0, 5'd0, 1'b0, 1'b1, 0));
        issue(r_ins(5'd1, 5'd2, 5'd9, 5'd0, 6'h04), 32'h123, 32'hF0, mk(4'd0, 32'h3, 32'hF0, 5'd9, 1'b1, 1'b0, 1));
        issue(i_ins(6'h04, 5'd1, 5'd2, 16'h0010), 32'd4, 32'd4, mk(4'd4, 32'd4, 32'd4, 5'd0, 1'b0, 1'b0, 0));
        issue(i_ins(6'h23, 5'd3, 5'd8, 16'h8000), 32'h2000, 32'h0, mk(4'd3, 32'h2000, 32'hFFFF_8000, 5'd8, 1'b1, 1'b0, 1));
        issue(i_ins(6'h0A, 5'd3, 5'd10, 16'h0005), 32'hFFFF_FFFE, 32'h0, mk(4'd9, 32'hFFFF_FFFE, 32'd5, 5'd10, 1'b1, 1'b0, 1));
        issue(r_ins(5'd4, 5'd5, 5'd11, 5'd0, 6'h27), 32'hA5A5_0000, 32'h0000_5A5A, mk(4'd8, 32'hA5A5_0000, 32'h0000_5A5A, 5'd11, 1'b1, 1'b0, 1));
        idle();
        chk("drain_valid", 32'(out_valid), 32'd0);
        chk("count_stream", 32'(out_issue_count), 32'(exp_count));
        chk("idle_holds_last", 32'(out_alu_opcode), 32'd8);

        // Backpressure: A loads, B waits three cycles, then both move on.
        out_ready = 1'b0;
        held = mk(4'd7, 32'h0F0F_0F0F, 32'h00FF_00FF, 5'd12, 1'b1, 1'b0, 1);
        issue(r_ins(5'd1, 5'd2, 5'd12, 5'd0, 6'h26), 32'h0F0F_0F0F, 32'h00FF_00FF, held);
        in_instruction = r_ins(5'd1, 5'd2, 5'd13, 5'd0, 6'h24);
        in_rs_data = 32'hFF00; in_rt_data = 32'h0FF0;
        for (int i = 0; i < 3; i++) begin
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            cycle();
            chk("bp_valid", 32'(out_valid), 32'd1);
            chk("bp_opcode", 32'(out_alu_opcode), 32'(held.opc));
            chk("bp_op1", out_operand1, held.op1);
            chk("bp_op2", out_operand2, held.op2);
            chk("bp_count", 32'(out_issue_count), 32'(exp_count));
        end
        out_ready = 1'b1;
        issue(in_instruction, 32'hFF00, 32'h0FF0, mk(4'd5, 32'hFF00, 32'h0FF0, 5'd13, 1'b1, 1'b0, 1));
        idle();
        chk("bp_count_after", 32'(out_issue_count), 32'(exp_count));

        // Flush drops the offered instruction without counting it.
        in_valid = 1'b1; flush = 1'b1;
        in_instruction = r_ins(5'd1, 5'd2, 5'd14, 5'd0, 6'h25);
        chk("flush_in_ready", 32'(in_ready), 32'd1);
        cycle();
        flush = 1'b0; in_valid = 1'b0;
        chk("flush_valid", 32'(out_valid), 32'd0);
        chk("flush_count", 32'(out_issue_count), 32'(exp_count));

        // Flush squashes a held entry the ALU never took.
        out_ready = 1'b0;
        issue(r_ins(5'd1, 5'd2, 5'd15, 5'd0, 6'h2A), 32'd1, 32'd2, mk(4'd9, 32'd1, 32'd2, 5'd15, 1'b1, 1'b0, 1));
        in_valid = 1'b0; flush = 1'b1;
        cycle();
        flush = 1'b0;
        chk("flush_held_valid", 32'(out_valid), 32'd0);
        void'(sb.pop_back());

        // Asynchronous reset in the middle of a held transfer.
        issue(r_ins(5'd1, 5'd2, 5'd16, 5'd0, 6'h23), 32'd8, 32'd3, mk(4'd4, 32'd8, 32'd3, 5'd16, 1'b1, 1'b0, 1));
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_opcode", 32'(out_alu_opcode), 32'd0);
        chk("mid_rst_op1", out_operand1, 32'd0);
        chk("mid_rst_op2", out_operand2, 32'd0);
        chk("mid_rst_dest", 32'(out_dest_reg), 32'd0);
        chk("mid_rst_rw", 32'(out_reg_write), 32'd0);
        chk("mid_rst_count", 32'(out_issue_count), 32'd0);
        sb.delete();
        exp_count = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;

        // Counter saturation at all-ones.
        for (int i = 0; i < 20; i++) begin
            issue(r_ins(5'd1, 5'd2, 5'd17, 5'd0, 6'h21), 32'(i), 32'(i * 3), mk(4'd3, 32'(i), 32'(i * 3), 5'd17, 1'b1, 1'b0, 1));
        end
        idle();
        chk("count_saturated", 32'(out_issue_count), 32'((1 << CW) - 1));
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
